// File: rtl/reg_bank_arb.sv
// reg_bank_arb: two-requester round-robin arbiter/sequencer in front of a
// bank of rw_reg storage registers.
//
// Each transaction takes IDLE -> EXEC -> RESP. At least 3 cycles pass
// between accepts.
//
// Ports:
//   clk_reg, rst_reg      - clock; synchronous active-high reset
//   rX_req_vld/rdy        - request handshake (rdy is combinational in IDLE)
//   rX_req_wr/addr/wdata  - request payload (1 = write)
//   rX_rsp_vld/rdy        - registered response handshake
//   rX_rsp_rdata/err      - read data (0 for writes/errors), out-of-range flag
//
// rw_reg: one storage register.
//   Synchronous active-low reset to DEFAULT_VALUE.
//   Loads data_in when wen is high.

module rw_reg #(
  parameter int                 DATA_W        = 32,
  parameter logic [DATA_W-1:0]  DEFAULT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_reg_n,
  input  logic              wen,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  // Storage flop with reset priority over write enable.
  always_ff @(posedge clk) begin
    if (!rst_reg_n) begin
      data_out <= DEFAULT_VALUE;
    end else if (wen) begin
      data_out <= data_in;
    end
  end

endmodule

module reg_bank_arb #(
  parameter int                 DATA_W        = 32,
  parameter int                 ADDR_W        = 4,
  parameter int                 N_REG         = 16,
  parameter logic [DATA_W-1:0]  DEFAULT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk_reg,
  input  logic              rst_reg,
  input  logic              r0_req_vld,
  output logic              r0_req_rdy,
  input  logic              r0_req_wr,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  output logic              r0_rsp_vld,
  input  logic              r0_rsp_rdy,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  output logic              r0_rsp_err,
  input  logic              r1_req_vld,
  output logic              r1_req_rdy,
  input  logic              r1_req_wr,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  output logic              r1_rsp_vld,
  input  logic              r1_rsp_rdy,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              r1_rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // One extra bit so N_REG == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(N_REG);

  state_t              state;
  state_t              next_state;
  logic                last_gnt;
  logic                gnt;
  logic                cap_wr;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic                sel_gnt;
  logic                accept;
  logic                rsp_hs;
  logic                in_range;
  logic                rst_reg_n;
  logic [N_REG-1:0]    wen;
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   data_out [N_REG];

  assign rst_reg_n = ~rst_reg;
  assign in_range  = ({1'b0, cap_addr} < ADDR_LIMIT);
  assign rsp_hs    = (state == RESP) && (gnt ? r1_rsp_rdy : r0_rsp_rdy);

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    sel_gnt = 1'b0;
    if (r0_req_vld && r1_req_vld) begin
      sel_gnt = ~last_gnt;
    end else if (r1_req_vld) begin
      sel_gnt = 1'b1;
    end else begin
      sel_gnt = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_reg) begin
    if (rst_reg) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? EXEC : IDLE;
      EXEC:    next_state = RESP;
      RESP:    next_state = rsp_hs ? IDLE : RESP;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: request ready, per-entry write enable and the read mux.
  always_comb begin
    accept     = (state == IDLE) && !rst_reg && (r0_req_vld || r1_req_vld);
    r0_req_rdy = accept && !sel_gnt;
    r1_req_rdy = accept && sel_gnt;
    rd_mux     = {DATA_W{1'b0}};
    for (int i = 0; i < N_REG; i++) begin
      wen[i] = (state == EXEC) && !rst_reg && cap_wr && (cap_addr == ADDR_W'(i));
      rd_mux = rd_mux | ({DATA_W{cap_addr == ADDR_W'(i)}} & data_out[i]);
    end
  end

  // Capture the granted request and advance the round-robin pointer on completion.
  always_ff @(posedge clk_reg) begin
    if (rst_reg) begin
      gnt       <= 1'b0;
      cap_wr    <= 1'b0;
      cap_addr  <= {ADDR_W{1'b0}};
      cap_wdata <= {DATA_W{1'b0}};
      last_gnt  <= 1'b1;
    end else begin
      if (accept) begin
        gnt       <= sel_gnt;
        cap_wr    <= sel_gnt ? r1_req_wr    : r0_req_wr;
        cap_addr  <= sel_gnt ? r1_req_addr  : r0_req_addr;
        cap_wdata <= sel_gnt ? r1_req_wdata : r0_req_wdata;
      end
      if (rsp_hs) begin
        last_gnt <= gnt;
      end
    end
  end

  // Response registers: loaded in EXEC, held through RESP, cleared on handshake.
  always_ff @(posedge clk_reg) begin
    if (rst_reg) begin
      r0_rsp_vld   <= 1'b0;
      r0_rsp_rdata <= {DATA_W{1'b0}};
      r0_rsp_err   <= 1'b0;
      r1_rsp_vld   <= 1'b0;
      r1_rsp_rdata <= {DATA_W{1'b0}};
      r1_rsp_err   <= 1'b0;
    end else if (state == EXEC) begin
      r0_rsp_vld   <= !gnt;
      r0_rsp_rdata <= (!gnt && !cap_wr && in_range) ? rd_mux : {DATA_W{1'b0}};
      r0_rsp_err   <= !gnt && !in_range;
      r1_rsp_vld   <= gnt;
      r1_rsp_rdata <= (gnt && !cap_wr && in_range) ? rd_mux : {DATA_W{1'b0}};
      r1_rsp_err   <= gnt && !in_range;
    end else if (rsp_hs) begin
      r0_rsp_vld   <= 1'b0;
      r0_rsp_rdata <= {DATA_W{1'b0}};
      r0_rsp_err   <= 1'b0;
      r1_rsp_vld   <= 1'b0;
      r1_rsp_rdata <= {DATA_W{1'b0}};
      r1_rsp_err   <= 1'b0;
    end
  end

  // Register bank.
  for (genvar i = 0; i < N_REG; i++) begin : g_bank
    rw_reg #(
      .DATA_W        (DATA_W),
      .DEFAULT_VALUE (DEFAULT_VALUE)
    ) u_reg (
      .clk       (clk_reg),
      .rst_reg_n (rst_reg_n),
      .wen       (wen[i]),
      .data_in   (cap_wdata),
      .data_out  (data_out[i])
    );
  end

endmodule

// File: tb/tb_reg_bank_arb.sv
// Self-checking bench for reg_bank_arb.
// The design is instantiated with N_REG = 12 so the out-of-range path is reachable.
// It uses a non-zero DEFAULT_VALUE so that reset values are distinguishable from zero.
module tb_reg_bank_arb;

  localparam int          DW  = 32;
  localparam int          AW  = 4;
  localparam int          NR  = 12;
  localparam logic [31:0] DEF = 32'h5A00_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_vld, req_rdy, req_wr, rsp_vld, rsp_rdy, rsp_err;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic [DW-1:0] rsp_rdata [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  reg_bank_arb #(.DATA_W(DW), .ADDR_W(AW), .N_REG(NR), .DEFAULT_VALUE(DEF)) dut (
    .clk_reg      (clk),
    .rst_reg      (rst),
    .r0_req_vld   (req_vld[0]),
    .r0_req_rdy   (req_rdy[0]),
    .r0_req_wr    (req_wr[0]),
    .r0_req_addr  (req_addr[0]),
    .r0_req_wdata (req_wdata[0]),
    .r0_rsp_vld   (rsp_vld[0]),
    .r0_rsp_rdy   (rsp_rdy[0]),
    .r0_rsp_rdata (rsp_rdata[0]),
    .r0_rsp_err   (rsp_err[0]),
    .r1_req_vld   (req_vld[1]),
    .r1_req_rdy   (req_rdy[1]),
    .r1_req_wr    (req_wr[1]),
    .r1_req_addr  (req_addr[1]),
    .r1_req_wdata (req_wdata[1]),
    .r1_rsp_vld   (rsp_vld[1]),
    .r1_rsp_rdy   (rsp_rdy[1]),
    .r1_rsp_rdata (rsp_rdata[1]),
    .r1_rsp_err   (rsp_err[1])
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [NR];
  int            last_served;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mem[i] = DEF;
    last_served = 1;
  endtask

  task automatic model_txn(input int p, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic [DW-1:0] er, output logic ee);
    ee = (int'(a) >= NR);
    er = '0;
    if (!ee) begin
      if (wr) mem[int'(a)] = d;
      else    er = mem[int'(a)];
    end
    last_served = p;
  endtask

  function automatic int first_port(input logic [1:0] v);
    if (v == 2'b11) return 1 - last_served;
    return (v == 2'b10) ? 1 : 0;
  endfunction

  // ---------------- transaction driver (records, does not judge) ----------------
  int            acc_cyc [2];
  int            rsp_cyc [2];
  int            order   [2];
  int            n_acc;
  logic [DW-1:0] got_rdata [2];
  logic          got_err   [2];
  bit            unstable  [2];
  bit            both_rdy, timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic serve(input logic [1:0] v, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int stall);
    logic [1:0] pend, done, drop;
    int held [2];
    int k;
    pend = v; done = ~v; n_acc = 0; both_rdy = 0; timed_out = 0; k = 0;
    for (int p = 0; p < 2; p++) begin
      held[p] = 0; unstable[p] = 0; acc_cyc[p] = -1; rsp_cyc[p] = -1;
      got_rdata[p] = '0; got_err[p] = 1'b0; order[p] = 0;
    end
    req_wr = wr; req_addr[0] = a0; req_addr[1] = a1;
    req_wdata[0] = d0; req_wdata[1] = d1; req_vld = v; rsp_rdy = 2'b00;
    while (done != 2'b11) begin
      #1;
      if (req_rdy == 2'b11) both_rdy = 1;
      drop = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && req_rdy[p]) begin
          acc_cyc[p] = cyc; order[n_acc] = p; n_acc++; pend[p] = 1'b0; drop[p] = 1'b1;
        end
        if (rsp_vld[p]) begin
          if (held[p] == 0) begin
            rsp_cyc[p] = cyc; got_rdata[p] = rsp_rdata[p]; got_err[p] = rsp_err[p];
          end else if (rsp_rdata[p] !== got_rdata[p] || rsp_err[p] !== got_err[p]) begin
            unstable[p] = 1;
          end
          rsp_rdy[p] = (held[p] >= stall);
          if (rsp_rdy[p]) done[p] = 1'b1;
          held[p]++;
        end else begin
          rsp_rdy[p] = 1'b0;
        end
      end
      tick();
      req_vld = req_vld & ~drop;
      k++;
      if (k > 80) begin
        timed_out = 1;
        break;
      end
    end
    req_vld = 2'b00;
    rsp_rdy = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] er;
    logic ee;
    rst = 1'b1; req_vld = 2'b11; req_wr = 2'b00; rsp_rdy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (req_rdy !== 2'b00 || rsp_vld !== 2'b00 || rsp_err !== 2'b00 ||
          rsp_rdata[0] !== '0 || rsp_rdata[1] !== '0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: rdy=%b rsp_vld=%b err=%b rdata0=%h rdata1=%h, required all zero",
                 i, req_rdy, rsp_vld, rsp_err, rsp_rdata[0], rsp_rdata[1]);
      end
    end
    rst = 1'b0; req_vld = 2'b00; rsp_rdy = 2'b00;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      int p;
      p = a % 2;
      serve((p == 0) ? 2'b01 : 2'b10, 2'b00, AW'(a), AW'(a), '0, '0, 0);
      model_txn(p, 1'b0, AW'(a), '0, er, ee);
      tests++;
      if (timed_out || got_rdata[p] !== er || got_err[p] !== ee) begin
        fails++;
        $display("FAIL reset_read addr %0d: got data=%h err=%b timeout=%0d, required data=%h err=%b",
                 a, got_rdata[p], got_err[p], timed_out, er, ee);
      end
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] er;
    logic ee;
    logic [DW-1:0] exp_q [$];
    int port_q [$];
    int n, k, prev, p, exp_p;
    n = 0; k = 0; prev = 0;
    req_wr = 2'b00; req_addr[0] = 4'd1; req_addr[1] = 4'd2;
    req_vld = 2'b11; rsp_rdy = 2'b11;
    exp_p = 1 - last_served;
    while (n < 6 && k < 60) begin
      #1;
      if (rsp_vld != 2'b00 && exp_q.size() > 0) begin
        p = port_q.pop_front();
        er = exp_q.pop_front();
        tests++;
        if (rsp_vld[p] !== 1'b1 || rsp_rdata[p] !== er || rsp_err[p] !== 1'b0) begin
          fails++;
          $display("FAIL contention_rsp port %0d: vld=%b data=%h, required data=%h", p, rsp_vld, rsp_rdata[p], er);
        end
      end
      if (req_rdy != 2'b00) begin
        p = req_rdy[1] ? 1 : 0;
        tests++;
        if (req_rdy == 2'b11 || p != exp_p) begin
          fails++;
          $display("FAIL contention_grant #%0d: rdy=%b, required port %0d", n, req_rdy, exp_p);
        end
        if (n > 0) begin
          tests++;
          if (cyc - prev != 3) begin
            fails++;
            $display("FAIL contention_spacing #%0d: %0d cycles, required 3", n, cyc - prev);
          end
        end
        prev = cyc;
        model_txn(p, 1'b0, req_addr[p], '0, er, ee);
        exp_q.push_back(er);
        port_q.push_back(p);
        exp_p = 1 - p;
        n++;
      end
      tick();
      k++;
    end
    req_vld = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp_vld != 2'b00 && exp_q.size() > 0) begin
        p = port_q.pop_front();
        er = exp_q.pop_front();
        tests++;
        if (rsp_vld[p] !== 1'b1 || rsp_rdata[p] !== er) begin
          fails++;
          $display("FAIL contention_rsp_last port %0d: vld=%b data=%h, required data=%h", p, rsp_vld, rsp_rdata[p], er);
        end
      end
      tick();
    end
    rsp_rdy = 2'b00;
    tests++;
    if (n != 6 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL contention_count: %0d accepts, %0d responses missing, required 6 and 0", n, exp_q.size());
    end
  endtask

  task automatic test_single_port();
    logic [DW-1:0] er;
    logic ee;
    serve(2'b01, 2'b01, 4'd5, 4'd0, 32'hDEADBEEF, '0, 0);
    model_txn(0, 1'b1, 4'd5, 32'hDEADBEEF, er, ee);
    tests++;
    if (timed_out || got_rdata[0] !== 32'h0 || got_err[0] !== 1'b0 || rsp_cyc[0] - acc_cyc[0] != 2) begin
      fails++;
      $display("FAIL single_write: data=%h err=%b latency=%0d, required 0/0/2",
               got_rdata[0], got_err[0], rsp_cyc[0] - acc_cyc[0]);
    end
    serve(2'b01, 2'b00, 4'd5, 4'd0, '0, '0, 0);
    model_txn(0, 1'b0, 4'd5, '0, er, ee);
    tests++;
    if (timed_out || got_rdata[0] !== 32'hDEADBEEF || got_rdata[0] !== er ||
        got_err[0] !== 1'b0 || rsp_cyc[0] - acc_cyc[0] != 2) begin
      fails++;
      $display("FAIL single_read: data=%h err=%b latency=%0d, required deadbeef/0/2",
               got_rdata[0], got_err[0], rsp_cyc[0] - acc_cyc[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] er;
    logic ee;
    serve(2'b10, 2'b10, 4'd0, 4'd13, '0, 32'h1234, 0);
    model_txn(1, 1'b1, 4'd13, 32'h1234, er, ee);
    tests++;
    if (timed_out || got_err[1] !== 1'b1 || got_rdata[1] !== 32'h0) begin
      fails++;
      $display("FAIL oor_write13: err=%b data=%h, required 1/0", got_err[1], got_rdata[1]);
    end
    serve(2'b01, 2'b01, 4'd11, 4'd0, 32'hCAFE_0011, '0, 0);
    model_txn(0, 1'b1, 4'd11, 32'hCAFE_0011, er, ee);
    tests++;
    if (timed_out || got_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL oor_write11: err=%b, required 0", got_err[0]);
    end
    serve(2'b01, 2'b01, 4'd12, 4'd0, 32'hBAD0_0012, '0, 0);
    model_txn(0, 1'b1, 4'd12, 32'hBAD0_0012, er, ee);
    tests++;
    if (timed_out || got_err[0] !== 1'b1 || got_rdata[0] !== 32'h0) begin
      fails++;
      $display("FAIL oor_write12: err=%b data=%h, required 1/0", got_err[0], got_rdata[0]);
    end
    for (int a = 0; a < NR; a++) begin
      int p;
      p = $urandom_range(0, 1);
      serve((p == 0) ? 2'b01 : 2'b10, 2'b00, AW'(a), AW'(a), '0, '0, 0);
      model_txn(p, 1'b0, AW'(a), '0, er, ee);
      tests++;
      if (timed_out || got_rdata[p] !== er || got_err[p] !== 1'b0) begin
        fails++;
        $display("FAIL oor_bank addr %0d: data=%h err=%b, required %h/0", a, got_rdata[p], got_err[p], er);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] er;
    logic ee;
    logic [AW-1:0] a0, a1;
    if (last_served == 0) begin
      serve(2'b10, 2'b00, 4'd0, 4'd0, '0, '0, 0);
      model_txn(1, 1'b0, 4'd0, '0, er, ee);
    end
    a0 = AW'($urandom_range(0, NR - 1));
    a1 = AW'($urandom_range(0, NR - 1));
    serve(2'b11, 2'b00, a0, a1, '0, '0, 5);
    model_txn(0, 1'b0, a0, '0, er, ee);
    tests++;
    if (timed_out || order[0] != 0 || got_rdata[0] !== er || unstable[0]) begin
      fails++;
      $display("FAIL bp_r0: first=%0d data=%h unstable=%0d, required 0/%h/0", order[0], got_rdata[0], unstable[0], er);
    end
    tests++;
    if (acc_cyc[1] != rsp_cyc[0] + 6) begin
      fails++;
      $display("FAIL bp_r1_accept: at cycle %0d, required %0d", acc_cyc[1], rsp_cyc[0] + 6);
    end
    model_txn(1, 1'b0, a1, '0, er, ee);
    tests++;
    if (got_rdata[1] !== er || unstable[1]) begin
      fails++;
      $display("FAIL bp_r1_data: data=%h, required %h", got_rdata[1], er);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] er, d0, d1;
    logic ee;
    logic [1:0] v, wr;
    logic [AW-1:0] a0, a1;
    int st, fp, p;
    for (int it = 0; it < 25; it++) begin
      v  = 2'($urandom_range(1, 3));
      wr = 2'($urandom_range(0, 3));
      a0 = AW'($urandom_range(0, 15));
      a1 = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a1 = a0;
      d0 = $urandom;
      d1 = $urandom;
      st = $urandom_range(0, 2);
      fp = first_port(v);
      serve(v, wr, a0, a1, d0, d1, st);
      tests++;
      if (timed_out || both_rdy || n_acc != ((v == 2'b11) ? 2 : 1) || order[0] != fp) begin
        fails++;
        $display("FAIL rand_order it %0d: timeout=%0d both_rdy=%0d accepts=%0d first=%0d, required first=%0d",
                 it, timed_out, both_rdy, n_acc, order[0], fp);
      end
      for (int j = 0; j < n_acc; j++) begin
        p = order[j];
        model_txn(p, wr[p], (p == 1) ? a1 : a0, (p == 1) ? d1 : d0, er, ee);
        tests++;
        if (got_rdata[p] !== er || got_err[p] !== ee || rsp_cyc[p] - acc_cyc[p] != 2 || unstable[p]) begin
          fails++;
          $display("FAIL rand_rsp it %0d port %0d: data=%h err=%b lat=%0d, required %h/%b/2",
                   it, p, got_rdata[p], got_err[p], rsp_cyc[p] - acc_cyc[p], er, ee);
        end
      end
      if (n_acc == 2) begin
        tests++;
        if (acc_cyc[order[1]] != rsp_cyc[order[0]] + st + 1) begin
          fails++;
          $display("FAIL rand_second_accept it %0d: cycle %0d, required %0d",
                   it, acc_cyc[order[1]], rsp_cyc[order[0]] + st + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen_vld, got_acc;
    seen_vld = 0; got_acc = 0;
    req_wr = 2'b01; req_addr[0] = 4'd3; req_wdata[0] = 32'hA5A5A5A5; req_vld = 2'b01;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req_rdy[0]) begin
        got_acc = 1;
        tick();
        break;
      end
      tick();
    end
    req_vld = 2'b00;
    rst = 1'b1;
    tick();
    if (rsp_vld != 2'b00) seen_vld = 1;
    tick();
    if (rsp_vld != 2'b00) seen_vld = 1;
    rst = 1'b0;
    model_reset();
    rsp_rdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_vld != 2'b00) seen_vld = 1;
    end
    rsp_rdy = 2'b00;
    tests++;
    if (!got_acc || seen_vld) begin
      fails++;
      $display("FAIL midrst_no_rsp: accepted=%0d rsp_vld_seen=%0d, required 1/0", got_acc, seen_vld);
    end
    serve(2'b11, 2'b00, 4'd3, 4'd4, '0, '0, 0);
    tests++;
    if (timed_out || order[0] != 0 || got_rdata[0] !== DEF || got_rdata[1] !== DEF) begin
      fails++;
      $display("FAIL midrst_after: first=%0d data3=%h data4=%h, required 0/%h/%h",
               order[0], got_rdata[0], got_rdata[1], DEF, DEF);
    end
  endtask

  initial begin
    rst = 1'b1; req_vld = 2'b00; req_wr = 2'b00; rsp_rdy = 2'b00;
    req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
    model_reset();
    test_reset();
    test_contention();
    test_single_port();
    test_out_of_range();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
